// File: rtl/byte_decode_stream.sv
// ---------------------------------------------------------------------------
// byte_decode_stream
//
// Unpacks a little-endian byte stream into D-bit coefficients. Bytes are
// appended to a small bit buffer; whenever at least D bits are buffered, the
// low D bits are offered as a coefficient. When D = 12, values >= Q are
// reduced once by subtracting Q. Coefficients are counted per polynomial of
// N_COEFF entries so the last one of each polynomial can be flagged.
//
// Handshakes: a transfer happens on a rising clk_i edge where valid and ready
// are both high. The producer must hold valid and data until ready is seen.
// This block holds coeff_o/coeff_last_o/coeff_valid_o steady until accepted.
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   clear_i        synchronous abort of the current polynomial
//   byte_valid_i   upstream byte valid
//   byte_i         upstream byte, consumed LSB first
//   byte_ready_o   byte accepted this cycle when byte_valid_i is high
//   coeff_valid_o  coefficient available
//   coeff_o        coefficient, zero-extended to 12 bits
//   coeff_last_o   coefficient N_COEFF-1 of the current polynomial
//   coeff_ready_i  downstream accepts the coefficient
// ---------------------------------------------------------------------------
module byte_decode_stream #(
    parameter int D       = 12,
    parameter int Q       = 3329,
    parameter int N_COEFF = 256
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        byte_ready_o,
    output logic        coeff_valid_o,
    output logic [11:0] coeff_o,
    output logic        coeff_last_o,
    input  logic        coeff_ready_i
);

    // In FILL at most D-1 bits are held, so one more byte needs D+7 bits.
    localparam int BW   = D + 7;
    localparam int CNTW = $clog2(D + 8);
    localparam int IDXW = (N_COEFF > 1) ? $clog2(N_COEFF) : 1;

    localparam logic [CNTW-1:0] CNT_D    = CNTW'(D);
    localparam logic [CNTW-1:0] CNT_BYTE = CNTW'(8);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N_COEFF - 1);

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [BW-1:0]     buf_q, buf_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    // Low during reset and until the first edge after release, so that
    // byte_ready_o only rises on a clock edge.
    logic              live_q;

    logic              byte_hs;
    logic              coeff_hs;
    logic [11:0]       raw;
    logic [11:0]       coeff;

    // clear_i masks both handshakes in its own cycle.
    assign byte_ready_o  = live_q & (state_q == FILL) & ~clear_i;
    assign coeff_valid_o = (state_q == EMIT) & ~clear_i;
    assign coeff_last_o  = coeff_valid_o & (idx_q == IDX_LAST);
    assign coeff_o       = coeff;

    assign byte_hs  = byte_valid_i & byte_ready_o;
    assign coeff_hs = coeff_valid_o & coeff_ready_i;

    // Coefficient straight from the registered buffer, single conditional
    // subtraction for the D = 12 case.
    always_comb begin
        raw        = '0;
        raw[D-1:0] = buf_q[D-1:0];
        if ((D == 12) && (raw >= 12'(Q))) begin
            coeff = raw - 12'(Q);
        end else begin
            coeff = raw;
        end
    end

    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (clear_i) begin
            buf_d = '0;
            cnt_d = '0;
            idx_d = '0;
        end else if (byte_hs) begin
            // Bits at and above cnt_q are always zero, so OR appends.
            buf_d = buf_q | (BW'(byte_i) << cnt_q);
            cnt_d = cnt_q + CNT_BYTE;
        end else if (coeff_hs) begin
            buf_d = buf_q >> D;
            cnt_d = cnt_q - CNT_D;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        state_d = (cnt_d >= CNT_D) ? EMIT : FILL;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FILL;
            buf_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            live_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_byte_decode_stream.sv
// Bench for byte_decode_stream. Four instances (D = 12, 10, 4, 1) share the
// clock, reset and clear. Inputs change 1 time unit after the rising edge;
// outputs are sampled on the falling edge.
module tb_byte_decode_stream;

  localparam int NC = 256;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        bv [4];
  logic [7:0]  bd [4];
  logic        br [4];
  logic        cv [4];
  logic [11:0] co [4];
  logic        cl [4];
  logic        cr [4];

  int n_chk;
  int n_err;

  // reference model state
  bit          bitq [$];
  logic [12:0] exp_q [$];
  int          model_idx;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  byte_decode_stream #(.D(12)) u_d12 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .byte_valid_i(bv[0]), .byte_i(bd[0]), .byte_ready_o(br[0]),
    .coeff_valid_o(cv[0]), .coeff_o(co[0]), .coeff_last_o(cl[0]),
    .coeff_ready_i(cr[0])
  );

  byte_decode_stream #(.D(10)) u_d10 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .byte_valid_i(bv[1]), .byte_i(bd[1]), .byte_ready_o(br[1]),
    .coeff_valid_o(cv[1]), .coeff_o(co[1]), .coeff_last_o(cl[1]),
    .coeff_ready_i(cr[1])
  );

  byte_decode_stream #(.D(4)) u_d4 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .byte_valid_i(bv[2]), .byte_i(bd[2]), .byte_ready_o(br[2]),
    .coeff_valid_o(cv[2]), .coeff_o(co[2]), .coeff_last_o(cl[2]),
    .coeff_ready_i(cr[2])
  );

  byte_decode_stream #(.D(1)) u_d1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .byte_valid_i(bv[3]), .byte_i(bd[3]), .byte_ready_o(br[3]),
    .coeff_valid_o(cv[3]), .coeff_o(co[3]), .coeff_last_o(cl[3]),
    .coeff_ready_i(cr[3])
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int d_of(input int k);
    case (k)
      0: return 12;
      1: return 10;
      2: return 4;
      default: return 1;
    endcase
  endfunction

  // ---------------- reference model ----------------
  task automatic model_reset();
    bitq.delete();
    exp_q.delete();
    model_idx = 0;
  endtask

  // Bits enter LSB first; every full group of D bits becomes a coefficient.
  task automatic model_push(input int k, input logic [7:0] b);
    int d;
    int v;
    d = d_of(k);
    for (int i = 0; i < 8; i++) bitq.push_back(b[i]);
    while (bitq.size() >= d) begin
      v = 0;
      for (int j = 0; j < d; j++) v = v + (int'(bitq.pop_front()) << j);
      if (d == 12 && v >= 3329) v = v - 3329;
      exp_q.push_back({(model_idx == NC - 1) ? 1'b1 : 1'b0, 12'(v)});
      model_idx = (model_idx + 1) % NC;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    for (int k = 0; k < 4; k++) begin
      bv[k] = 1'b0;
      bd[k] = 8'h00;
      cr[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    #3 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_eq("rst_valid", 32'(cv[k]), 0);
      check_eq("rst_coeff", 32'(co[k]), 0);
      check_eq("rst_last", 32'(cl[k]), 0);
      check_eq("rst_ready", 32'(br[k]), 0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("ready_before_edge", 32'(br[0]), 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) check_eq("ready_after_edge", 32'(br[k]), 1);
    model_reset();
  endtask

  task automatic push_byte(input int k, input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    bv[k] = 1'b1;
    bd[k] = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (br[k]) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("push_accepted", 32'(ok), 1);
    @(posedge clk);
    #1;
    bv[k] = 1'b0;
  endtask

  task automatic pop_coeff(input int k, input string tag, input logic [11:0] exp);
    bit ok;
    ok = 1'b0;
    cr[k] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cv[k]) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq({tag, "_valid"}, 32'(ok), 1);
    check_eq(tag, 32'(co[k]), 32'(exp));
    @(posedge clk);
    #1;
    cr[k] = 1'b0;
  endtask

  // Random byte stream with random downstream readiness, checked against
  // the reference model. With drain set, keeps going until every expected
  // coefficient has come out.
  task automatic run_stream(input int k, input int nbytes, input bit drain, input int rdy_pct);
    int          sent;
    int          budget;
    bit          have;
    bit          done;
    logic [7:0]  cur;
    bit          prev_v;
    logic [12:0] prev;
    logic [12:0] e;
    sent   = 0;
    have   = 1'b0;
    done   = 1'b0;
    prev_v = 1'b0;
    prev   = '0;
    cur    = 8'h00;
    budget = nbytes * 30 + 400;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (!have && sent < nbytes && $urandom_range(0, 99) < 80) begin
        cur  = 8'($urandom);
        have = 1'b1;
      end
      bv[k] = have;
      bd[k] = have ? cur : 8'($urandom);
      cr[k] = ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      check_eq("exclusive", 32'(br[k] & cv[k]), 0);
      if (prev_v) begin
        check_eq("hold_valid", 32'(cv[k]), 1);
        check_eq("hold_data", 32'({cl[k], co[k]}), 32'(prev));
      end
      if (cv[k] && cr[k]) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_coeff", 32'(cv[k]), 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("coeff", 32'(co[k]), 32'(e[11:0]));
          check_eq("last", 32'(cl[k]), 32'(e[12]));
        end
        prev_v = 1'b0;
      end else if (cv[k]) begin
        prev_v = 1'b1;
        prev   = {cl[k], co[k]};
      end else begin
        prev_v = 1'b0;
      end
      if (have && br[k]) begin
        model_push(k, cur);
        have = 1'b0;
        sent++;
      end
      @(posedge clk);
      #1;
      if (sent == nbytes && !have && (!drain || exp_q.size() == 0)) begin
        done = 1'b1;
        break;
      end
    end
    bv[k] = 1'b0;
    cr[k] = 1'b0;
    check_eq("stream_done", 32'(done), 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b1;
    clear = 1'b0;
    idle_inputs();
    model_reset();
    do_reset();

    // D = 4: 0xA5 -> 5, 10, then nothing until the next byte
    push_byte(2, 8'hA5);
    pop_coeff(2, "d4_c0", 12'd5);
    pop_coeff(2, "d4_c1", 12'd10);
    cr[2] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("d4_no_third", 32'(cv[2]), 0);
      @(posedge clk);
      #1;
    end
    cr[2] = 1'b0;
    push_byte(2, 8'h3C);
    pop_coeff(2, "d4_c2", 12'd12);
    pop_coeff(2, "d4_c3", 12'd3);

    // D = 1: 0x81 -> 1,0,0,0,0,0,0,1 with byte_ready low throughout
    push_byte(3, 8'h81);
    cr[3] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("d1_valid", 32'(cv[3]), 1);
      check_eq("d1_coeff", 32'(co[3]), (i == 0 || i == 7) ? 1 : 0);
      check_eq("d1_ready_low", 32'(br[3]), 0);
      @(posedge clk);
      #1;
    end
    cr[3] = 1'b0;
    @(negedge clk);
    check_eq("d1_ready_back", 32'(br[3]), 1);
    check_eq("d1_drained", 32'(cv[3]), 0);
    @(posedge clk);
    #1;

    // D = 12: reduction and boundaries
    push_byte(0, 8'hFF);
    push_byte(0, 8'hFF);
    pop_coeff(0, "d12_4095a", 12'd766);
    push_byte(0, 8'hFF);
    pop_coeff(0, "d12_4095b", 12'd766);
    push_byte(0, 8'h01);
    push_byte(0, 8'h0D);
    pop_coeff(0, "d12_3329", 12'd0);
    push_byte(0, 8'h00);
    pop_coeff(0, "d12_zero", 12'd0);
    push_byte(0, 8'h00);
    push_byte(0, 8'h0D);
    pop_coeff(0, "d12_3328", 12'd3328);
    push_byte(0, 8'h00);
    pop_coeff(0, "d12_zero2", 12'd0);
    push_byte(0, 8'h01);
    push_byte(0, 8'hD0);
    pop_coeff(0, "d12_one", 12'd1);
    push_byte(0, 8'h00);
    pop_coeff(0, "d12_13", 12'd13);

    // backpressure at D = 12: 0x34,0x12 -> 0x234 held for 5 cycles
    do_reset();
    push_byte(0, 8'h34);
    push_byte(0, 8'h12);
    cr[0] = 1'b0;
    bv[0] = 1'b1;
    bd[0] = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_valid", 32'(cv[0]), 1);
      check_eq("bp_coeff", 32'(co[0]), 564);
      check_eq("bp_last", 32'(cl[0]), 0);
      check_eq("bp_ready_low", 32'(br[0]), 0);
      @(posedge clk);
      #1;
    end
    bv[0] = 1'b0;
    pop_coeff(0, "bp_pop", 12'd564);
    push_byte(0, 8'h56);
    pop_coeff(0, "bp_next", 12'd1377);

    // full polynomials with random stimulus
    do_reset();
    run_stream(1, 640, 1'b1, 70);
    do_reset();
    run_stream(2, 256, 1'b1, 60);
    do_reset();
    run_stream(3, 64, 1'b1, 75);
    do_reset();
    run_stream(0, 384, 1'b1, 65);

    // abort by reset after 7 bytes, then a clean polynomial
    do_reset();
    run_stream(0, 7, 1'b0, 50);
    do_reset();
    run_stream(0, 384, 1'b1, 70);

    // abort by clear after 7 bytes, then a clean polynomial
    do_reset();
    run_stream(0, 7, 1'b0, 50);
    bv[0] = 1'b1;
    bd[0] = 8'hA5;
    cr[0] = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    check_eq("clr_ready_low", 32'(br[0]), 0);
    check_eq("clr_valid_low", 32'(cv[0]), 0);
    check_eq("clr_last_low", 32'(cl[0]), 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    bv[0] = 1'b0;
    cr[0] = 1'b0;
    @(negedge clk);
    check_eq("clr_after_ready", 32'(br[0]), 1);
    check_eq("clr_after_valid", 32'(cv[0]), 0);
    check_eq("clr_after_coeff", 32'(co[0]), 0);
    @(posedge clk);
    #1;
    model_reset();
    run_stream(0, 384, 1'b1, 70);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
